// File: rtl/detector_sequencer.sv
// Serializes a latched word into the single-bit detector and collects its Moore hits.
// DETSEQ_LSB_FIRST_EN: transmit LSB first instead of the default MSB first.
module detector_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_w,
  output logic             det_en,
  output logic             det_clr,
  input  logic             det_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hits,
  output logic [CNT_W-1:0] out_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             samp_en;
  logic [IDX_W-1:0] samp_k;

  // Maps the transmit slot k to the word bit it carries.
  function automatic logic [IDX_W-1:0] tx_pos(input logic [IDX_W-1:0] k);
`ifdef DETSEQ_LSB_FIRST_EN
    return k;
`else
    return LAST - k;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      hits_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      hits_q  <= hits_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    hits_d  = hits_q;
    count_d = count_q;
    samp_en = 1'b0;
    samp_k  = idx_q - IDX_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CLEAR;
          data_d  = in_data;
          hits_d  = '0;
          count_d = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_SHIFT;
        idx_d   = '0;
      end
      S_SHIFT: begin
        // z lags the driven bit by one cycle, so slot 0 has nothing to sample.
        samp_en = (idx_q != '0);
        if (idx_q == LAST) state_d = S_DRAIN;
        else idx_d = idx_q + IDX_W'(1);
      end
      S_DRAIN: begin
        samp_en = 1'b1;
        samp_k  = LAST;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (samp_en && det_z) begin
      hits_d[tx_pos(samp_k)] = 1'b1;
      count_d = count_q + CNT_W'(1);
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign det_clr   = (state_q == S_CLEAR);
  assign det_en    = (state_q == S_SHIFT);
  assign det_w     = det_en & data_q[tx_pos(idx_q)];
  assign out_valid = (state_q == S_DONE);
  assign out_hits  = hits_q;
  assign out_count = count_q;

endmodule
